// File: rtl/logic_gates.sv
// Registered AND/OR/NOT gates with per-input synchronizer chains.
// Five asynchronous pins are synchronized, then combined into registered c, f, h.
module logic_gates #(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic a,
  input  logic b,
  output logic c,
  input  logic d,
  input  logic e,
  output logic f,
  input  logic g,
  output logic h
);

  localparam int unsigned N_IN = 5;

  // Bit order of the synchronizer vector: {g, e, d, b, a}
  logic [N_IN-1:0] sync_q [SYNC_STAGES];
  logic [N_IN-1:0] pins_c;
  logic [N_IN-1:0] sync_c;

  assign pins_c = {g, e, d, b, a};
  assign sync_c = sync_q[SYNC_STAGES-1];

  // Synchronizer chains; every stage clears so no stale sample survives reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      sync_q[0] <= pins_c;
      for (int i = 1; i < int'(SYNC_STAGES); i++) begin
        sync_q[i] <= sync_q[i-1];
      end
    end
  end

  // Output registers; NOT of the cleared chain makes h come up 1 after reset
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      c <= 1'b0;
      f <= 1'b0;
      h <= 1'b0;
    end else begin
      c <= sync_c[0] & sync_c[1];
      f <= sync_c[2] | sync_c[3];
      h <= ~sync_c[4];
    end
  end

endmodule

// File: tb/tb_logic_gates.sv
// Scoreboard bench for logic_gates at SYNC_STAGES = 1, 2 and 4.
// Expected {c,f,h} are queued as inputs are driven and popped once the latency elapses.
module tb_logic_gates;

  logic clk;
  logic rst_n;
  logic a, b, d, e, g;
  logic c1, f1, h1;
  logic c2, f2, h2;
  logic c4, f4, h4;

  logic [2:0] q1[$];
  logic [2:0] q2[$];
  logic [2:0] q4[$];
  logic [2:0] last_exp;

  int n_vec;
  int n_err;

  logic_gates #(.SYNC_STAGES(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c1), .d(d), .e(e), .f(f1), .g(g), .h(h1)
  );
  logic_gates #(.SYNC_STAGES(2)) dut2 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c2), .d(d), .e(e), .f(f2), .g(g), .h(h2)
  );
  logic_gates #(.SYNC_STAGES(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .a(a), .b(b), .c(c4), .d(d), .e(e), .f(f4), .g(g), .h(h4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [2:0] model(input logic [4:0] v);
    // v = {g, e, d, b, a}; result = {c, f, h}
    return {v[0] & v[1], v[2] | v[3], ~v[4]};
  endfunction

  task automatic drive(input logic [4:0] v);
    a = v[0]; b = v[1]; d = v[2]; e = v[3]; g = v[4];
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    drive(5'b11111);
    #3;
    n_vec++;
    if ({c1, f1, h1, c2, f2, h2, c4, f4, h4} !== 9'b0) begin
      $display("FAIL reset_async: got %b want 000000000", {c1, f1, h1, c2, f2, h2, c4, f4, h4});
      n_err++;
    end
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({c1, f1, h1, c2, f2, h2, c4, f4, h4} !== 9'b0) begin
        $display("FAIL reset_hold[%0d]: got %b want 000000000", i, {c1, f1, h1, c2, f2, h2, c4, f4, h4});
        n_err++;
      end
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if ({c1, f1, h1} !== 3'b001 || {c2, f2, h2} !== 3'b001 || {c4, f4, h4} !== 3'b001) begin
      $display("FAIL reset_first_edge: got s1=%b s2=%b s4=%b want 001 each",
               {c1, f1, h1}, {c2, f2, h2}, {c4, f4, h4});
      n_err++;
    end
  endtask

  task automatic test_all_zero;
    @(negedge clk);
    drive(5'b00000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    n_vec++;
    if ({c2, f2, h2} !== 3'b001) begin
      $display("FAIL all_zero: got cfh=%b want 001", {c2, f2, h2});
      n_err++;
    end
    last_exp = 3'b001;
  endtask

  // Directed vector on the default-latency instance: unchanged at edges 1-2, new at edge 3
  task automatic test_directed(input logic [4:0] v, input string name);
    logic [2:0] exp;
    @(negedge clk);
    drive(v);
    q2.push_back(model(v));
    for (int k = 1; k <= 2; k++) begin
      @(posedge clk); #1;
      n_vec++;
      if ({c2, f2, h2} !== last_exp) begin
        $display("FAIL %s_edge%0d: got cfh=%b want %b", name, k, {c2, f2, h2}, last_exp);
        n_err++;
      end
    end
    @(posedge clk); #1;
    exp = q2.pop_front();
    n_vec++;
    if ({c2, f2, h2} !== exp) begin
      $display("FAIL %s_edge3: got cfh=%b want %b", name, {c2, f2, h2}, exp);
      n_err++;
    end
    last_exp = exp;
  endtask

  task automatic test_async_midcycle;
    #3;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if ({c1, f1, h1, c2, f2, h2, c4, f4, h4} !== 9'b0) begin
      $display("FAIL midcycle_reset: got %b want 000000000", {c1, f1, h1, c2, f2, h2, c4, f4, h4});
      n_err++;
    end
    q2.delete();
  endtask

  // Streaming sweep: all three instances checked every cycle against queued expectations
  task automatic test_back_to_back;
    logic [2:0] exp;
    q1.delete(); q2.delete(); q4.delete();
    @(negedge clk);
    drive(5'b00000);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int v = 0; v < 32; v++) begin
      for (int k = 0; k < 4; k++) begin
        @(negedge clk);
        drive(5'(v));
        q1.push_back(model(5'(v)));
        q2.push_back(model(5'(v)));
        q4.push_back(model(5'(v)));
        @(posedge clk); #1;
        if (q1.size() > 1) begin
          exp = q1.pop_front();
          n_vec++;
          if ({c1, f1, h1} !== exp) begin
            $display("FAIL sweep_s1 v=%0d: got cfh=%b want %b", v, {c1, f1, h1}, exp);
            n_err++;
          end
        end
        if (q2.size() > 2) begin
          exp = q2.pop_front();
          n_vec++;
          if ({c2, f2, h2} !== exp) begin
            $display("FAIL sweep_s2 v=%0d: got cfh=%b want %b", v, {c2, f2, h2}, exp);
            n_err++;
          end
        end
        if (q4.size() > 4) begin
          exp = q4.pop_front();
          n_vec++;
          if ({c4, f4, h4} !== exp) begin
            $display("FAIL sweep_s4 v=%0d: got cfh=%b want %b", v, {c4, f4, h4}, exp);
            n_err++;
          end
        end
      end
    end
    q1.delete(); q2.delete(); q4.delete();
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    last_exp = 3'b000;
    test_reset();
    test_all_zero();
    //                 {g,e,d,b,a}
    test_directed(5'b10101, "a_d_g");
    test_directed(5'b11010, "b_e_g");
    test_directed(5'b11111, "all_ones");
    test_async_midcycle();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/logic_gates.md
# logic_gates

Registered elementary-gate block: three independent Boolean functions (AND, OR, NOT) over five single-bit inputs. Inputs cross into the clock domain through synchronizer chains; each result is held in an output register. The block sits at the board-I/O edge of lab designs, between switch inputs and LED outputs, and doubles as a gate-level reference for verification flows.

## Interface
Parameters:
- SYNC_STAGES, default 2: flip-flops per input synchronizer chain; legal range 1-4.

Ports:
- clk  input  1  single system clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous, active-low reset; assertion takes effect immediately, release is sampled on clk.
- a  input  1  AND operand 0 (asynchronous source).
- b  input  1  AND operand 1 (asynchronous source).
- c  output  1  registered a AND b.
- d  input  1  OR operand 0 (asynchronous source).
- e  input  1  OR operand 1 (asynchronous source).
- f  output  1  registered d OR e.
- g  input  1  NOT operand (asynchronous source).
- h  output  1  registered NOT g.

## Operation
- Each of a, b, d, e, g passes through its own SYNC_STAGES-deep flip-flop chain; the chain output is the synchronized value (a_s, b_s, d_s, e_s, g_s).
- Output register next state: c <= a_s & b_s; f <= d_s | e_s; h <= ~g_s.
- All three functions are independent; a change on one input never affects an unrelated output.
- No enable, no handshake: outputs update every clock.
- Reset (rst_n = 0): every synchronizer flop clears to 0; c, f, h clear to 0 immediately, without waiting for clk.
- Because synchronizers reset to 0, the first rising edge after reset release loads h = 1 (NOT of synchronized 0), c = 0, f = 0, regardless of current pin levels; true pin values appear after the full latency.
- Reset asserted mid-operation discards all in-flight samples; no partial results survive.
- Inputs are never combinationally connected to outputs.

## Timing
- Latency: an input change stable before rising edge N is reflected on the outputs after edge N + SYNC_STAGES (SYNC_STAGES + 1 edges total; 3 edges at default).
- Inputs changing simultaneously (e.g. a and b on the same edge) appear on c on the same edge; no glitch or intermediate value on c, f, h, since each is a single register bit.
- Pulses shorter than one clock period may be missed; input events must hold for at least one full clk period to be guaranteed observed.
- Outputs change only on rising clk edges, except the immediate clear on rst_n assertion.
- Reset release must meet recovery/removal to clk; synchronizing rst_n is the integrator's responsibility.

## Test plan
- Reset: hold rst_n = 0 with all inputs 1 -> c = 0, f = 0, h = 0 throughout; first edge after release -> h = 1, c = 0, f = 0.
- All inputs 0 after reset, wait 3 edges -> c = 0, f = 0, h = 1.
- Set a = 1, d = 1, g = 1 (b = 0, e = 0) -> after 3 edges c = 0, f = 1, h = 0; outputs unchanged at edges 1 and 2.
- Set a = 0, b = 1, d = 0, e = 1 (g = 1) -> after 3 edges c = 0, f = 1, h = 0.
- Set a = 1, b = 1, d = 1, e = 1, g = 1 -> after 3 edges c = 1, f = 1, h = 0; then drop rst_n asynchronously mid-cycle -> c, f, h = 0 before the next edge.
- Sweep all 32 input combinations, each held 4 cycles, with SYNC_STAGES = 1 and 4 -> outputs match AND/OR/NOT exactly after 2 and 5 edges respectively.
